// File: rtl/uart_rx_oversample.sv
// UART receiver driven by a 16x baud tick: synchronises and majority-filters rx,
// validates the start bit, samples bits at their centres and presents a byte with status.
module uart_rx_oversample (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud_clock,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       read_rx_byte,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow,
  output logic       rx_busy
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SAMP_W = 4;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned FILT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t              r_state;
  logic                r_sync1;
  logic                r_sync2;
  logic [FILT_W-1:0]   r_filt;
  logic [SAMP_W-1:0]   r_samp_cntr;
  logic [BIT_W-1:0]    r_bit_cntr;
  logic [DATA_W-1:0]   r_shift;
  logic                r_bit8;
  logic                r_par_en;
  logic                r_odd;
  logic                r_pbit;
  logic                r_stop;
  logic                r_done;
  logic                r_busy;
  logic [DATA_W-1:0]   r_rx_data;
  logic                r_rx_ready;
  logic                r_parity_err;
  logic                r_framing_err;
  logic                r_overflow;

  logic                w_rx_filt;
  logic [BIT_W-1:0]    w_last_bit;
  logic [DATA_W-1:0]   w_data;
  logic                w_par_err;

  assign w_rx_filt  = (r_filt[0] & r_filt[1]) | (r_filt[0] & r_filt[2]) | (r_filt[1] & r_filt[2]);
  assign w_last_bit = r_bit8 ? BIT_W'(7) : BIT_W'(6);
  // 7-bit frames leave the data in the top seven bits of the right-shifting register
  assign w_data     = r_bit8 ? r_shift : {1'b0, r_shift[DATA_W-1:1]};
  assign w_par_err  = r_par_en & (^w_data ^ r_pbit ^ r_odd);

  // Metastability synchroniser and tick-rate majority filter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_filt  <= '1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      if (baud_clock) r_filt <= {r_filt[FILT_W-2:0], r_sync2};
    end
  end

  // Frame FSM, advanced only on baud ticks
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_samp_cntr <= '0;
      r_bit_cntr  <= '0;
      r_shift     <= '0;
      r_bit8      <= 1'b0;
      r_par_en    <= 1'b0;
      r_odd       <= 1'b0;
      r_pbit      <= 1'b0;
      r_stop      <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (baud_clock) begin
        r_samp_cntr <= r_samp_cntr + SAMP_W'(1);
        case (r_state)
          S_IDLE: begin
            if (!w_rx_filt) begin
              r_state     <= S_START;
              r_samp_cntr <= '0;
              r_bit8      <= bit8;
              r_par_en    <= parity_en;
              r_odd       <= odd_n_even;
              r_busy      <= 1'b1;
            end
          end
          S_START: begin
            if (r_samp_cntr == SAMP_W'(7)) begin
              if (!w_rx_filt) begin
                r_state     <= S_DATA;
                r_samp_cntr <= '0;
                r_bit_cntr  <= '0;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end
          end
          S_DATA: begin
            if (r_samp_cntr == SAMP_W'(15)) begin
              r_shift    <= {w_rx_filt, r_shift[DATA_W-1:1]};
              r_bit_cntr <= r_bit_cntr + BIT_W'(1);
              if (r_bit_cntr == w_last_bit) r_state <= r_par_en ? S_PARITY : S_STOP;
            end
          end
          S_PARITY: begin
            if (r_samp_cntr == SAMP_W'(15)) begin
              r_pbit  <= w_rx_filt;
              r_state <= S_STOP;
            end
          end
          S_STOP: begin
            if (r_samp_cntr == SAMP_W'(15)) begin
              r_stop <= w_rx_filt;
              r_done <= 1'b1;
              if (w_rx_filt) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_state <= S_WAIT_HIGH;
              end
            end
          end
          S_WAIT_HIGH: begin
            // A break holds the line low; wait for idle rather than re-triggering
            if (w_rx_filt) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Output holding register; a completion takes priority over a same-cycle read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_data     <= '0;
      r_rx_ready    <= 1'b0;
      r_parity_err  <= 1'b0;
      r_framing_err <= 1'b0;
      r_overflow    <= 1'b0;
    end else if (r_done) begin
      if (!r_rx_ready || read_rx_byte) begin
        r_rx_data     <= w_data;
        r_rx_ready    <= 1'b1;
        r_parity_err  <= w_par_err;
        r_framing_err <= ~r_stop;
      end else begin
        r_overflow <= 1'b1;
      end
    end else if (read_rx_byte && r_rx_ready) begin
      r_rx_ready    <= 1'b0;
      r_parity_err  <= 1'b0;
      r_framing_err <= 1'b0;
      r_overflow    <= 1'b0;
    end
  end

  assign rx_data     = r_rx_data;
  assign rx_ready    = r_rx_ready;
  assign parity_err  = r_parity_err;
  assign framing_err = r_framing_err;
  assign overflow    = r_overflow;
  assign rx_busy     = r_busy;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample: baud tick every 4 clk, 64 clk per bit.
module tb_uart_rx_oversample;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       baud_clock;
  logic       rx;
  logic       bit8;
  logic       parity_en;
  logic       odd_n_even;
  logic       read_rx_byte;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       parity_err;
  logic       framing_err;
  logic       overflow;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;

  uart_rx_oversample dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .baud_clock   (baud_clock),
    .rx           (rx),
    .bit8         (bit8),
    .parity_en    (parity_en),
    .odd_n_even   (odd_n_even),
    .read_rx_byte (read_rx_byte),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .parity_err   (parity_err),
    .framing_err  (framing_err),
    .overflow     (overflow),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    baud_clock = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 baud_clock = 1'b1;
      @(posedge clk);
      #1 baud_clock = 1'b0;
    end
  end

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx = bits[i];
      repeat (BIT_CLKS) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic is8, input logic pen,
                            input logic pbit, input logic stopb);
    logic [10:0] b;
    int n;
    int nd;
    b  = '0;
    nd = is8 ? 8 : 7;
    for (int i = 0; i < nd; i++) b[1+i] = data[i];
    n = 1 + nd;
    if (pen) begin
      b[n] = pbit;
      n++;
    end
    b[n] = stopb;
    n++;
    send_bits(b, n);
  endtask

  task automatic do_read();
    read_rx_byte = 1'b1;
    @(posedge clk);
    #1 read_rx_byte = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rx_data); end
    checks++;
    if ({rx_ready, parity_err, framing_err, overflow, rx_busy} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000", {rx_ready, parity_err, framing_err, overflow, rx_busy});
    end
    reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_8n1();
    int k;
    bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    send_bits(11'h14A, 9);
    rx = 1'b1;
    k = 0;
    while (rx_busy !== 1'b0 && k < 200) begin @(posedge clk); #1; k++; end
    checks++;
    if (k >= 200) begin errors++; $display("FAIL t1_stop_timeout: busy got %b expected 0", rx_busy); end
    checks++;
    if (rx_ready !== 1'b0) begin errors++; $display("FAIL t1_latency: rx_ready got %b expected 0 on stop tick", rx_ready); end
    @(posedge clk); #1;
    checks++;
    if (rx_ready !== 1'b1) begin errors++; $display("FAIL t1_ready: got %b expected 1", rx_ready); end
    checks++;
    if (rx_data !== 8'hA5) begin errors++; $display("FAIL t1_data: got %h expected a5", rx_data); end
    checks++;
    if ({parity_err, framing_err, overflow, rx_busy} !== 4'b0) begin
      errors++; $display("FAIL t1_status: got %b expected 0000", {parity_err, framing_err, overflow, rx_busy});
    end
    repeat (BIT_CLKS) @(posedge clk); #1;
    do_read();
    checks++;
    if (rx_ready !== 1'b0) begin errors++; $display("FAIL t1_read_clear: got %b expected 0", rx_ready); end
  endtask

  task automatic test_7e1_parity();
    bit8 = 1'b0; parity_en = 1'b1; odd_n_even = 1'b0;
    send_frame(8'h35, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (rx_data !== 8'h35) begin errors++; $display("FAIL t2_data: got %h expected 35", rx_data); end
    checks++;
    if ({rx_ready, parity_err, framing_err} !== 3'b100) begin
      errors++; $display("FAIL t2_good_parity: got %b expected 100", {rx_ready, parity_err, framing_err});
    end
    do_read();
    send_frame(8'h35, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({rx_ready, parity_err, rx_data} !== {2'b11, 8'h35}) begin
      errors++; $display("FAIL t2_bad_parity: got %b/%b/%h expected 1/1/35", rx_ready, parity_err, rx_data);
    end
    do_read();
    checks++;
    if (parity_err !== 1'b0) begin errors++; $display("FAIL t2_perr_clear: got %b expected 0", parity_err); end
    odd_n_even = 1'b1;
    send_frame(8'h35, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({rx_ready, parity_err} !== 2'b10) begin
      errors++; $display("FAIL t2_odd_parity: got %b expected 10", {rx_ready, parity_err});
    end
    do_read();
  endtask

  task automatic test_glitch();
    bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    rx = 1'b0;
    repeat (16) @(posedge clk);
    #1 rx = 1'b1;
    repeat (4) @(posedge clk); #1;
    checks++;
    if (rx_busy !== 1'b1) begin errors++; $display("FAIL t3_start_seen: busy got %b expected 1", rx_busy); end
    repeat (2 * BIT_CLKS) @(posedge clk); #1;
    checks++;
    if ({rx_busy, rx_ready} !== 2'b00) begin
      errors++; $display("FAIL t3_rejected: busy/ready got %b expected 00", {rx_busy, rx_ready});
    end
  endtask

  task automatic test_framing();
    bit8 = 1'b1; parity_en = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (2 * BIT_CLKS) @(posedge clk); #1;
    checks++;
    if ({rx_ready, framing_err, parity_err, rx_data} !== {3'b110, 8'h3C}) begin
      errors++; $display("FAIL t4_framing: got %b/%b/%b/%h expected 1/1/0/3c", rx_ready, framing_err, parity_err, rx_data);
    end
    checks++;
    if ({rx_busy, overflow} !== 2'b10) begin
      errors++; $display("FAIL t4_break_hold: busy/ovf got %b expected 10", {rx_busy, overflow});
    end
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(posedge clk); #1;
    checks++;
    if ({rx_busy, overflow, rx_ready} !== 3'b001) begin
      errors++; $display("FAIL t4_no_retrigger: busy/ovf/ready got %b expected 001", {rx_busy, overflow, rx_ready});
    end
    do_read();
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({rx_ready, framing_err, rx_data} !== {2'b10, 8'h11}) begin
      errors++; $display("FAIL t4_recover: got %b/%b/%h expected 1/0/11", rx_ready, framing_err, rx_data);
    end
    do_read();
  endtask

  task automatic test_overflow();
    send_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(8'h02, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({rx_ready, overflow, rx_data} !== {2'b11, 8'h01}) begin
      errors++; $display("FAIL t5_overflow: got %b/%b/%h expected 1/1/01", rx_ready, overflow, rx_data);
    end
    do_read();
    checks++;
    if ({rx_ready, parity_err, framing_err, overflow} !== 4'b0) begin
      errors++; $display("FAIL t5_read_clear: got %b expected 0000", {rx_ready, parity_err, framing_err, overflow});
    end
    do_read();
    checks++;
    if ({rx_ready, rx_data} !== {1'b0, 8'h01}) begin
      errors++; $display("FAIL t5_idle_read: got %b/%h expected 0/01", rx_ready, rx_data);
    end
  endtask

  task automatic test_read_race_and_reset();
    int k;
    send_frame(8'hAA, 1'b1, 1'b0, 1'b0, 1'b1);
    send_bits({2'b00, 8'h55, 1'b0}, 9);
    rx = 1'b1;
    k = 0;
    while (rx_busy !== 1'b0 && k < 200) begin @(posedge clk); #1; k++; end
    checks++;
    if (k >= 200) begin errors++; $display("FAIL t6_stop_timeout: busy got %b expected 0", rx_busy); end
    read_rx_byte = 1'b1;
    @(posedge clk);
    #1 read_rx_byte = 1'b0;
    checks++;
    if ({rx_ready, overflow, rx_data} !== {2'b10, 8'h55}) begin
      errors++; $display("FAIL t6_race: got %b/%b/%h expected 1/0/55", rx_ready, overflow, rx_data);
    end
    repeat (BIT_CLKS) @(posedge clk); #1;
    send_bits({3'b000, 8'h0D}, 4);
    checks++;
    if (rx_busy !== 1'b1) begin errors++; $display("FAIL t6_mid_frame: busy got %b expected 1", rx_busy); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({rx_data, rx_ready, parity_err, framing_err, overflow, rx_busy} !== 13'b0) begin
      errors++; $display("FAIL t6_async_reset: got %h/%b expected 00/00000", rx_data, {rx_ready, parity_err, framing_err, overflow, rx_busy});
    end
    rx = 1'b1;
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2 * BIT_CLKS) @(posedge clk); #1;
    send_frame(8'h96, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({rx_ready, parity_err, framing_err, overflow, rx_data} !== {4'b1000, 8'h96}) begin
      errors++; $display("FAIL t6_after_reset: got %b/%h expected 1000/96", {rx_ready, parity_err, framing_err, overflow}, rx_data);
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    rx           = 1'b1;
    bit8         = 1'b1;
    parity_en    = 1'b0;
    odd_n_even   = 1'b0;
    read_rx_byte = 1'b0;
    test_reset();
    test_8n1();
    test_7e1_parity();
    test_glitch();
    test_framing();
    test_overflow();
    test_read_race_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
